number_display_driver: RTL and testbench

//  Drives the digit-bitmap renderer for a multi-digit decimal readout (score/timer) on the VGA path.

---
 rtl/number_display_pkg.sv | 15 +
 rtl/bin2bcd_seq.sv | 130 +++++++++++++
 rtl/number_display_driver.sv | 109 ++++++++++
 tb/tb_number_display_driver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/number_display_pkg.sv
// Shared geometry, FSM states and digit type for the decimal readout.
package number_display_pkg;

   localparam int unsigned DIGIT_W = 16;
   localparam int unsigned DIGIT_H = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } fsm_t;

   typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with a one-deep pending slot.
module bin2bcd_seq
   import number_display_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned VALUE_WIDTH = 14
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    start,
   input  logic [VALUE_WIDTH-1:0]  bin,
   output logic                    busy,
   output logic                    done,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic                    ovf
);

   localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
   localparam int unsigned SR_W    = VALUE_WIDTH + BCD_W;
   localparam int unsigned CNT_W   = $clog2(VALUE_WIDTH + 1);
   localparam int unsigned MAX_VAL = 10 ** NUM_DIGITS;
   localparam logic [BCD_W-1:0] ALL_NINES = {NUM_DIGITS{4'd9}};

   fsm_t                   state_q, state_d;
   logic [SR_W-1:0]        sr_q, sr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   wovf_q, wovf_d;
   logic                   pend_q, pend_d;
   logic [VALUE_WIDTH-1:0] pend_val_q, pend_val_d;
   logic                   busy_d, done_d, ovf_d;
   logic [BCD_W-1:0]       bcd_d;
   logic                   load_go;
   logic [VALUE_WIDTH-1:0] load_val;

   // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
   function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] s);
      logic [SR_W-1:0] t;
      t = s;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (t[VALUE_WIDTH + 4*i +: 4] >= 4'd5)
            t[VALUE_WIDTH + 4*i +: 4] = t[VALUE_WIDTH + 4*i +: 4] + 4'd3;
      end
      return {t[SR_W-2:0], 1'b0};
   endfunction

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= IDLE;
         sr_q       <= '0;
         cnt_q      <= '0;
         wovf_q     <= 1'b0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         bcd        <= '0;
         ovf        <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         wovf_q     <= wovf_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         busy       <= busy_d;
         done       <= done_d;
         bcd        <= bcd_d;
         ovf        <= ovf_d;
      end
   end

   // Next-state, pending-slot and conversion-step logic.
   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      cnt_d      = cnt_q;
      wovf_d     = wovf_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      done_d     = 1'b0;
      bcd_d      = bcd;
      ovf_d      = ovf;
      load_go    = 1'b0;
      load_val   = bin;

      unique case (state_q)
         IDLE: begin
            if (start) load_go = 1'b1;
         end
         SHIFT: begin
            if (start) begin
               pend_d     = 1'b1;
               pend_val_d = bin;
            end
            sr_d  = dabble_step(sr_q);
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(VALUE_WIDTH - 1)) begin
               state_d = COMMIT;
               done_d  = 1'b1;
               bcd_d   = wovf_q ? ALL_NINES : sr_d[SR_W-1 -: BCD_W];
               ovf_d   = wovf_q;
            end
         end
         COMMIT: begin
            state_d = IDLE;
            pend_d  = 1'b0;
            // A load arriving in the commit cycle is newer than the pending one.
            if (start) begin
               load_go  = 1'b1;
               load_val = bin;
            end else if (pend_q) begin
               load_go  = 1'b1;
               load_val = pend_val_q;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load_go) begin
         state_d = SHIFT;
         sr_d    = {BCD_W'(0), load_val};
         cnt_d   = '0;
         wovf_d  = (32'(load_val) >= MAX_VAL);
      end

      busy_d = (state_d != IDLE);
   end

endmodule

// File: rtl/number_display_driver.sv
// Decimal readout driver: BCD display register, leading-zero blanking and per-pixel glyph geometry.
module number_display_driver
   import number_display_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned VALUE_WIDTH   = 14,
   parameter int unsigned TOP_LEFT_X    = 16,
   parameter int unsigned TOP_LEFT_Y    = 16,
   parameter int unsigned BLANK_LEADING = 1
) (
   input  logic                   clk,
   input  logic                   resetN,
   input  logic [10:0]            pixelX,
   input  logic [10:0]            pixelY,
   input  logic [VALUE_WIDTH-1:0] value,
   input  logic                   valueLoad,
   output logic [10:0]            offsetX,
   output logic [10:0]            offsetY,
   output logic                   InsideRectangle,
   output logic [3:0]             digit,
   output logic                   busy,
   output logic                   overflow
);

   localparam int unsigned COORD_W = 11;
   localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
   localparam int unsigned LOG2W   = $clog2(DIGIT_W);
   localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic               conv_done;
   logic               conv_ovf;
   logic [BCD_W-1:0]   conv_bcd;
   logic [BCD_W-1:0]   disp_q;
   bcd_digit_t         digs [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] blank;
   logic [COORD_W-1:0] rel_x, rel_y;
   logic               in_cell;
   logic [IDX_W-1:0]   idx;
   bcd_digit_t         sel_digit;
   logic               sel_blank;

   bin2bcd_seq #(
      .NUM_DIGITS (NUM_DIGITS),
      .VALUE_WIDTH(VALUE_WIDTH)
   ) u_bin2bcd (
      .clk   (clk),
      .resetN(resetN),
      .start (valueLoad),
      .bin   (value),
      .busy  (busy),
      .done  (conv_done),
      .bcd   (conv_bcd),
      .ovf   (conv_ovf)
   );

   // Committed display register; updated atomically when a conversion finishes.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         disp_q   <= '0;
         overflow <= 1'b0;
      end else if (conv_done) begin
         disp_q   <= conv_bcd;
         overflow <= conv_ovf;
      end
   end

   // Split display into digits (index 0 = leftmost) and build the leading-zero blank mask.
   always_comb begin : blank_mask
      logic zero_run;
      zero_run = 1'b1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         digs[i]  = disp_q[BCD_W - 1 - 4*i -: 4];
         zero_run = zero_run && (digs[i] == 4'd0);
         blank[i] = (BLANK_LEADING != 0) && zero_run && (i != int'(NUM_DIGITS) - 1);
      end
   end

   // Pixel geometry: offsets relative to the readout and the glyph cell being scanned.
   always_comb begin
      rel_x     = pixelX - COORD_W'(TOP_LEFT_X);
      rel_y     = pixelY - COORD_W'(TOP_LEFT_Y);
      in_cell   = (rel_x < COORD_W'(NUM_DIGITS * DIGIT_W)) && (rel_y < COORD_W'(DIGIT_H));
      idx       = rel_x[LOG2W +: IDX_W];
      sel_digit = '0;
      sel_blank = 1'b1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (idx == IDX_W'(i)) begin
            sel_digit = digs[i];
            sel_blank = blank[i];
         end
      end
   end

   // Single pipeline stage for the renderer inputs.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         offsetX         <= '0;
         offsetY         <= '0;
         InsideRectangle <= 1'b0;
         digit           <= '0;
      end else begin
         InsideRectangle <= in_cell && !sel_blank;
         offsetX         <= in_cell ? (rel_x & COORD_W'(DIGIT_W - 1)) : '0;
         offsetY         <= in_cell ? rel_y : '0;
         digit           <= in_cell ? sel_digit : '0;
      end
   end

endmodule

// File: tb/tb_number_display_driver.sv
// Scoreboard bench for number_display_driver: stimulus pushes expectations, monitors pop and compare.
module tb_number_display_driver;

   logic        clk = 1'b0;
   logic        resetN;
   logic [10:0] pixelX, pixelY;
   logic [13:0] value;
   logic        valueLoad;
   logic [10:0] offsetX, offsetY;
   logic        InsideRectangle;
   logic [3:0]  digit;
   logic        busy, overflow;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          id;
      logic        ins;
      logic [3:0]  dig;
      logic [10:0] ox;
      logic [10:0] oy;
   } pix_exp_t;

   typedef struct {
      int   len;
      logic ovf;
   } conv_exp_t;

   pix_exp_t  pix_q[$];
   conv_exp_t conv_q[$];

   logic probe_v   = 1'b0;
   logic probe_d   = 1'b0;
   int   probe_id  = 0;
   int   busy_len  = 0;
   logic busy_prev = 1'b0;

   number_display_driver dut (
      .clk            (clk),
      .resetN         (resetN),
      .pixelX         (pixelX),
      .pixelY         (pixelY),
      .value          (value),
      .valueLoad      (valueLoad),
      .offsetX        (offsetX),
      .offsetY        (offsetY),
      .InsideRectangle(InsideRectangle),
      .digit          (digit),
      .busy           (busy),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Pixel monitor: compares registered outputs one clock after a probe was presented.
   always @(posedge clk) probe_d <= probe_v;

   always @(negedge clk) begin
      if (probe_d) begin
         if (pix_q.size() == 0) begin
            chk("pix_queue_underflow", 32'd1, 32'd0);
         end else begin
            pix_exp_t e;
            e = pix_q.pop_front();
            chk($sformatf("pix%0d_inside", e.id), InsideRectangle, e.ins);
            chk($sformatf("pix%0d_digit", e.id), digit, e.dig);
            chk($sformatf("pix%0d_offx", e.id), offsetX, e.ox);
            chk($sformatf("pix%0d_offy", e.id), offsetY, e.oy);
         end
      end
   end

   // Conversion monitor: each busy episode ends in a commit; check its length and overflow.
   always @(negedge clk) begin
      if (!resetN) begin
         busy_len  = 0;
         busy_prev = 1'b0;
      end else begin
         if (busy === 1'b1) begin
            busy_len++;
         end else if (busy_prev) begin
            if (conv_q.size() == 0) begin
               chk("conv_queue_underflow", 32'd1, 32'd0);
            end else begin
               conv_exp_t c;
               c = conv_q.pop_front();
               chk("busy_len", 32'(busy_len), 32'(c.len));
               chk("overflow", overflow, c.ovf);
            end
            busy_len = 0;
         end
         busy_prev = busy;
      end
   end

   task automatic load(input logic [13:0] v, input int len, input logic ovf, input bit push);
      conv_exp_t c;
      @(posedge clk);
      #1;
      value     = v;
      valueLoad = 1'b1;
      if (push) begin
         c.len = len;
         c.ovf = ovf;
         conv_q.push_back(c);
      end
      @(posedge clk);
      #1;
      valueLoad = 1'b0;
   endtask

   task automatic probe(input int x, input int y, input logic ins, input int dig,
                        input int ox, input int oy);
      pix_exp_t e;
      @(posedge clk);
      #1;
      pixelX = 11'(x);
      pixelY = 11'(y);
      e.id   = probe_id;
      e.ins  = ins;
      e.dig  = 4'(dig);
      e.ox   = 11'(ox);
      e.oy   = 11'(oy);
      pix_q.push_back(e);
      probe_id++;
      probe_v = 1'b1;
      @(posedge clk);
      #1;
      probe_v = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle", busy, 1'b0);
   endtask

   initial begin
      resetN    = 1'b0;
      value     = '0;
      valueLoad = 1'b0;
      pixelX    = '0;
      pixelY    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_inside", InsideRectangle, 1'b0);
      chk("rst_digit", digit, 4'd0);
      chk("rst_offx", offsetX, 11'd0);
      chk("rst_offy", offsetY, 11'd0);
      resetN = 1'b1;

      // Reset in the middle of converting 1234 aborts it
      pixelX = 11'd68;
      pixelY = 11'd20;
      load(14'd1234, 0, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("pre_abort_busy", busy, 1'b1);
      chk("pre_abort_inside", InsideRectangle, 1'b1);
      #1;
      resetN = 1'b0;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_inside", InsideRectangle, 1'b0);
      chk("abort_offx", offsetX, 11'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("abort_hold_inside", InsideRectangle, 1'b0);
      chk("abort_hold_offy", offsetY, 11'd0);
      resetN = 1'b1;
      probe(68, 20, 1'b1, 0, 4, 4);
      probe(33, 21, 1'b0, 0, 1, 5);
      chk("post_abort_idle", busy, 1'b0);

      // 1234: cells 1,2,3,4 and corner offsets
      load(14'd1234, 15, 1'b0, 1'b1);
      wait_idle();
      probe(16, 16, 1'b1, 1, 0, 0);
      probe(33, 21, 1'b1, 2, 1, 5);
      probe(50, 47, 1'b1, 3, 2, 31);
      probe(79, 16, 1'b1, 4, 15, 0);
      probe(15, 16, 1'b0, 0, 0, 0);

      // Leading-zero blanking
      load(14'd7, 15, 1'b0, 1'b1);
      wait_idle();
      probe(20, 20, 1'b0, 0, 4, 4);
      probe(50, 20, 1'b0, 0, 2, 4);
      probe(68, 20, 1'b1, 7, 4, 4);
      load(14'd0, 15, 1'b0, 1'b1);
      wait_idle();
      probe(68, 20, 1'b1, 0, 4, 4);
      probe(60, 20, 1'b0, 0, 12, 4);

      // Overflow saturates to 9999, next in-range load clears it
      load(14'd12000, 15, 1'b1, 1'b1);
      wait_idle();
      probe(16, 16, 1'b1, 9, 0, 0);
      probe(79, 47, 1'b1, 9, 15, 31);
      load(14'd5, 15, 1'b0, 1'b1);
      wait_idle();
      probe(68, 16, 1'b1, 5, 4, 0);

      // Back-to-back loads: 111 commits, 222 is overwritten by 333, busy never drops
      load(14'd111, 30, 1'b0, 1'b1);
      load(14'd222, 0, 1'b0, 1'b0);
      load(14'd333, 0, 1'b0, 1'b0);
      repeat (15) @(posedge clk);
      probe(68, 16, 1'b1, 1, 4, 0);
      probe(33, 16, 1'b1, 1, 1, 0);
      wait_idle();
      probe(68, 16, 1'b1, 3, 4, 0);
      probe(16, 16, 1'b0, 0, 0, 0);
      probe(80, 16, 1'b0, 0, 0, 0);
      probe(16, 48, 1'b0, 0, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("pix_queue_left", 32'(pix_q.size()), 32'd0);
      chk("conv_queue_left", 32'(conv_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
